// File: rtl/div_seq_pkg.sv
// div_seq_pkg: shared divider state encoding and sizing constants
package div_seq_pkg;
  typedef enum logic [1:0] {IDLE, ZERO, RUN, DONE} div_state_t;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);
endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring division step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] nextRem,
  output logic [WIDTH-1:0] nextDividend,
  output logic             qBit
);
  logic [WIDTH:0] trial;
  // trial subtract; the difference always fits WIDTH bits when it is kept
  always_comb begin
    trial        = {rem, dividend[WIDTH-1]};
    qBit         = trial >= {1'b0, divisor};
    nextRem      = qBit ? trial[WIDTH-1:0] - divisor : trial[WIDTH-1:0];
    nextDividend = {dividend[WIDTH-2:0], qBit};
  end
endmodule

// File: rtl/div_seq.sv
// div_seq: iterative DIV/DIVU sequencer producing hi (remainder) and lo (quotient)
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             annul,
  input  logic             stall_ext,
  output logic             stall,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  div_state_t state, nextState;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] rem, dvd, dsr, nextRem, nextDvd, absA, absB;
  logic negQ, negR, qBit, last, bZero, accept;
  div_step #(.WIDTH(WIDTH)) uStep (
    .rem(rem),
    .dividend(dvd),
    .divisor(dsr),
    .nextRem(nextRem),
    .nextDividend(nextDvd),
    .qBit(qBit)
  );
  // operand magnitudes, control decodes and handshake outputs
  always_comb begin
    absA   = signed_div && a[WIDTH-1] ? -a : a;
    absB   = signed_div && b[WIDTH-1] ? -b : b;
    bZero  = b == '0;
    last   = cnt == CW'(WIDTH - 1);
    accept = state == IDLE && start && !annul;
    stall  = accept || state == RUN || state == ZERO;
    ready  = state == DONE;
  end
  // next state; a flush overrides everything
  always_comb begin
    nextState = state;
    nextState = annul ? IDLE :
                state == IDLE ? (start ? (bZero ? ZERO : RUN) : IDLE) :
                state == RUN  ? (last ? DONE : RUN) :
                state == ZERO ? DONE :
                (stall_ext ? DONE : IDLE);
  end
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nextState;
  // operand capture, iteration and result registers; quotient accumulates in dvd
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt  <= '0;
      rem  <= '0;
      dvd  <= '0;
      dsr  <= '0;
      negQ <= 1'b0;
      negR <= 1'b0;
      hi   <= '0;
      lo   <= '0;
    end else if (!annul) begin
      if (accept) begin
        cnt  <= '0;
        rem  <= '0;
        dvd  <= bZero ? a : absA;
        dsr  <= absB;
        negQ <= signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
        negR <= signed_div && a[WIDTH-1];
      end
      if (state == RUN) begin
        rem <= nextRem;
        dvd <= nextDvd;
        cnt <= cnt + CW'(1);
        if (last) begin
          hi <= negR ? -nextRem : nextRem;
          lo <= negQ ? -nextDvd : nextDvd;
        end
      end
      if (state == ZERO) begin
        hi <= dvd;
        lo <= '1;
      end
    end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq
module tb_div_seq;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, signed_div = 1'b0, annul = 1'b0, stall_ext = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic stall, ready;
  logic [31:0] hi, lo;
  int errors = 0, checks = 0;

  div_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .a(a), .b(b),
    .annul(annul), .stall_ext(stall_ext), .stall(stall), .ready(ready), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic divide(input logic sd, input logic [31:0] av, input logic [31:0] bv,
                        output int cyc, output int stallCnt);
    @(negedge clk);
    start = 1'b1; signed_div = sd; a = av; b = bv;
    cyc = 0; stallCnt = 0;
    #1;
    while (!ready && cyc < 100) begin
      if (stall) stallCnt++;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", stall); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", ready); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo got=%h want=0", {hi, lo}); end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_unsigned;
    int c, s;
    divide(1'b0, 32'd100, 32'd7, c, s);
    checks++; if (c !== 33) begin errors++; $display("FAIL udiv_latency got=%0d want=33", c); end
    checks++; if (s !== 33) begin errors++; $display("FAIL udiv_stall_cycles got=%0d want=33", s); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL udiv_stall_done got=%b want=0", stall); end
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL udiv_result got=%h/%h want=0000000e/00000002", lo, hi); end
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL udiv_ready_pulse got=%b want=0", ready); end
  endtask

  task automatic test_signed;
    int c, s;
    divide(1'b1, 32'hFFFFFFF9, 32'd2, c, s);
    checks++; if (c !== 33) begin errors++; $display("FAIL sdiv1_latency got=%0d want=33", c); end
    checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL sdiv1_result got=%h/%h want=fffffffd/ffffffff", lo, hi); end
    @(negedge clk);
    divide(1'b1, 32'd7, 32'hFFFFFFFE, c, s);
    checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'd1) begin errors++; $display("FAIL sdiv2_result got=%h/%h want=fffffffd/00000001", lo, hi); end
    @(negedge clk);
    divide(1'b0, 32'hFFFFFFF9, 32'd2, c, s);
    checks++; if (lo !== 32'h7FFFFFFC || hi !== 32'd1) begin errors++; $display("FAIL udiv_big_result got=%h/%h want=7ffffffc/00000001", lo, hi); end
    @(negedge clk);
  endtask

  task automatic test_overflow;
    int c, s;
    divide(1'b1, 32'h80000000, 32'hFFFFFFFF, c, s);
    checks++; if (c !== 33) begin errors++; $display("FAIL ovf_latency got=%0d want=33", c); end
    checks++; if (lo !== 32'h80000000 || hi !== 32'h0) begin errors++; $display("FAIL ovf_result got=%h/%h want=80000000/00000000", lo, hi); end
    @(negedge clk);
  endtask

  task automatic test_div_zero;
    int c, s;
    divide(1'b1, 32'h1234, 32'h0, c, s);
    checks++; if (c !== 2) begin errors++; $display("FAIL dz_latency got=%0d want=2", c); end
    checks++; if (s !== 2) begin errors++; $display("FAIL dz_stall_cycles got=%0d want=2", s); end
    checks++; if (lo !== 32'hFFFFFFFF || hi !== 32'h1234) begin errors++; $display("FAIL dz_result got=%h/%h want=ffffffff/00001234", lo, hi); end
    @(negedge clk);
  endtask

  task automatic test_annul;
    int c, s;
    bit sawReady;
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; a = 32'd1000; b = 32'd3;
    repeat (10) @(negedge clk);
    annul = 1'b1; start = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (stall !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL annul_idle got=stall%b ready%b want=0 0", stall, ready); end
    checks++; if (lo !== 32'hFFFFFFFF || hi !== 32'h1234) begin errors++; $display("FAIL annul_hold got=%h/%h want=ffffffff/00001234", lo, hi); end
    annul = 1'b0;
    sawReady = 1'b0;
    repeat (40) begin @(negedge clk); if (ready) sawReady = 1'b1; end
    checks++; if (sawReady !== 1'b0) begin errors++; $display("FAIL annul_no_ready got=%b want=0", sawReady); end
    divide(1'b0, 32'd1000, 32'd3, c, s);
    checks++; if (c !== 33 || lo !== 32'd333 || hi !== 32'd1) begin errors++; $display("FAIL annul_restart got=%0d %h/%h want=33 0000014d/00000001", c, lo, hi); end
    @(negedge clk);
  endtask

  task automatic test_annul_start;
    @(negedge clk);
    start = 1'b1; annul = 1'b1; a = 32'd9; b = 32'd3;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL annul_start_stall got=%b want=0", stall); end
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    #1;
    checks++; if (stall !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL annul_start_idle got=stall%b ready%b want=0 0", stall, ready); end
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL annul_start_no_run got=%b want=0", ready); end
  endtask

  task automatic test_hold;
    int c, s;
    stall_ext = 1'b1;
    divide(1'b0, 32'd45, 32'd6, c, s);
    checks++; if (c !== 33 || lo !== 32'd7 || hi !== 32'd3) begin errors++; $display("FAIL hold_result got=%0d %h/%h want=33 00000007/00000003", c, lo, hi); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (ready !== 1'b1 || lo !== 32'd7 || hi !== 32'd3 || stall !== 1'b0) begin errors++; $display("FAIL hold_cycle%0d got=rdy%b stall%b %h/%h want=1 0 00000007/00000003", i, ready, stall, lo, hi); end
    end
    stall_ext = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (ready !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL hold_release got=rdy%b stall%b want=0 0", ready, stall); end
  endtask

  task automatic test_back_to_back;
    int c, s;
    divide(1'b0, 32'hFFFFFFFF, 32'h10, c, s);
    checks++; if (c !== 33 || lo !== 32'h0FFFFFFF || hi !== 32'hF) begin errors++; $display("FAIL b2b_first got=%0d %h/%h want=33 0fffffff/0000000f", c, lo, hi); end
    divide(1'b1, 32'hFFFFFF9C, 32'd7, c, s);
    checks++; if (c !== 33 || lo !== 32'hFFFFFFF2 || hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL b2b_second got=%0d %h/%h want=33 fffffff2/fffffffe", c, lo, hi); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start = 1'b1; signed_div = 1'b0; a = 32'd500; b = 32'd9;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0; start = 1'b0;
    #1;
    checks++; if (stall !== 1'b0 || ready !== 1'b0 || {hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_mid got=stall%b rdy%b %h want=0 0 0", stall, ready, {hi, lo}); end
    @(negedge clk); rst = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (ready !== 1'b0 || {hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_mid_quiet got=rdy%b %h want=0 0", ready, {hi, lo}); end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_overflow;
    test_div_zero;
    test_annul;
    test_annul_start;
    test_hold;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/div_seq.md
# div_seq

Iterative multi-cycle divider sequencer for the pipelined MIPS core's execute stage. It executes DIV and DIVU: it captures operands when the decoded divide reaches execute, runs a radix-2 restoring division over WIDTH cycles, and asserts a stall so the front of the pipeline holds. It then delivers the remainder and quotient as the HI and LO write data for the hilo register.

## Interface
- WIDTH, 32, operand width; result is 2*WIDTH.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  divide instruction valid in execute stage; level, held while stalled.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- a  input  WIDTH  dividend (rs); sampled with start.
- b  input  WIDTH  divisor (rt); sampled with start.
- annul  input  1  execute-stage flush (flushE); cancels any operation.
- stall_ext  input  1  execute stage held by another hazard.
- stall  output  1  divider requests pipeline stall.
- ready  output  1  hi/lo valid for the instruction in execute.
- hi  output  WIDTH  remainder.
- lo  output  WIDTH  quotient.

## Operation
- FSM states: IDLE, ZERO, RUN, DONE.
- IDLE:
  - start=1 and annul=0 with b≠0: latch |a|, |b| and the sign flags, clear the counter, go to RUN.
  - start=1 and annul=0 with b=0: go to ZERO.
- RUN:
  - Each cycle: partial remainder = {rem, dividend MSB} − divisor. If non-negative, keep the difference and shift in quotient bit 1; otherwise restore and shift in 0.
  - The counter runs 0..WIDTH-1. At WIDTH-1, register the sign-corrected result and go to DONE.
- ZERO: one cycle. Result lo = all ones, hi = a (unmodified). Go to DONE. There is no exception.
- DONE:
  - ready=1.
  - stall_ext=1: stay in DONE with the result held.
  - stall_ext=0: go to IDLE. start is not re-sampled in DONE.
- Signed correction:
  - Quotient is negated when sign(a)≠sign(b).
  - Remainder takes the sign of a.
  - Absolute value and negation wrap mod 2^WIDTH, so 0x80000000 / −1 yields lo=0x80000000, hi=0.
- annul=1 in any state: go to IDLE next edge, no ready, hi/lo unchanged.
- hi/lo are registered and hold their last result until the next DONE or ZERO completion.

## Timing
- Reset values:
  - state = IDLE; stall, ready = 0.
  - hi, lo, counter = 0; operand registers = 0.
- stall (combinational) = (IDLE & start & ~annul) | RUN | ZERO.
  - Deasserted in DONE so the instruction advances when stall_ext=0.
- Latency with start seen at edge 0:
  - RUN occupies cycles 1..WIDTH.
  - DONE/ready in cycle WIDTH+1, i.e. 33 cycles for WIDTH=32.
  - Divide-by-zero: ready in cycle 2.
- ready is a single-cycle pulse unless extended by stall_ext. hi/lo are stable whenever ready=1.
- Simultaneous events:
  - annul and start together in IDLE: annul wins, no stall.
  - annul in DONE: IDLE next edge, no result update.
- A back-to-back divide is accepted in IDLE the cycle after DONE.
- Reset mid-operation aborts immediately (asynchronous) with no output pulse.

## Structure
- Shared package, alongside the other core definitions:
  - div_state_t enum (IDLE, ZERO, RUN, DONE).
  - DIV_WIDTH default of 32.
  - Counter width constant $clog2(WIDTH).
- One natural sub-module: div_step. It is combinational and computes one restoring step, taking {rem, dividend, divisor} and producing {next_rem, next_dividend, qbit}.
- Sign handling and the FSM stay in div_seq.

## Test plan
- Unsigned: a=100, b=7, signed_div=0 → stall for 33 cycles, ready in cycle 33, lo=14, hi=2.
- Signed: a=−7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). Also a=7, b=−2 → lo=−3, hi=1.
- Overflow: a=0x80000000, b=0xFFFFFFFF, signed → lo=0x80000000, hi=0, no hang.
- Divide by zero: a=0x1234, b=0 → ready in cycle 2, lo=0xFFFFFFFF, hi=0x1234.
- Flush: annul=1 at RUN cycle 10 → IDLE next cycle, stall=0, no ready, hi/lo keep previous values. A new start afterwards completes normally.
- External hold plus reset:
  - stall_ext=1 for 3 cycles in DONE → ready stays high with a stable result, no restart.
  - rst low mid-RUN → all outputs 0 immediately.
